// File: rtl/vproc_mem_model.sv
// Parametrised single-port memory model for VProc benches: byte enables,
// programmable read/write latency, and generated wr_ack/rd_ack/err pulses.
module vproc_mem_model #(
   parameter int          DATA_WIDTH = 32,
   parameter int          ADDR_WIDTH = 10,
   parameter int          DEPTH      = 1024,
   parameter int          RD_LATENCY = 1,
   parameter int          WR_LATENCY = 1,
   parameter logic [31:0] ERR_DATA   = 32'hDEADC0DE
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cs,
   input  logic                    we,
   input  logic                    rd,
   input  logic [DATA_WIDTH/8-1:0] be,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic [DATA_WIDTH-1:0]   di,
   output logic [DATA_WIDTH-1:0]   dout,
   output logic                    wr_ack,
   output logic                    rd_ack,
   output logic                    err
);

   localparam int                  NB      = DATA_WIDTH / 8;
   localparam int                  IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0]         DEPTH_L = 32'(DEPTH);
   localparam logic [DATA_WIDTH-1:0] ERR_D = DATA_WIDTH'(ERR_DATA);

   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

   state_t                r_state, w_next;
   logic [2:0]            r_cnt;
   logic                  r_op_wr, r_err, r_oob;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_di;
   logic [NB-1:0]         r_be;
   logic [DATA_WIDTH-1:0] r_dout;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic                  w_accept, w_in_oob, w_acc_now, w_wait_done, w_complete;
   logic                  w_c_wr, w_c_oob;
   int                    w_lat;
   logic [ADDR_WIDTH-1:0] w_c_addr;
   logic [DATA_WIDTH-1:0] w_c_di;
   logic [NB-1:0]         w_c_be;
   logic [IDX_W-1:0]      w_idx;

   // The ACK cycle accepts like IDLE so a requester can issue back-to-back.
   assign w_accept    = (r_state != WAIT) && cs && (we || rd);
   assign w_lat       = we ? WR_LATENCY : RD_LATENCY;
   assign w_in_oob    = (32'(addr) >= DEPTH_L);
   assign w_acc_now   = w_accept && (w_lat == 1);
   assign w_wait_done = (r_state == WAIT) && (r_cnt == 3'd0);
   assign w_complete  = w_acc_now || w_wait_done;

   // Latency-1 accesses complete on live inputs; longer ones on latched copies.
   assign w_c_wr   = w_accept ? we       : r_op_wr;
   assign w_c_oob  = w_accept ? w_in_oob : r_oob;
   assign w_c_addr = w_accept ? addr     : r_addr;
   assign w_c_di   = w_accept ? di       : r_di;
   assign w_c_be   = w_accept ? be       : r_be;
   assign w_idx    = w_c_addr[IDX_W-1:0];

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, ACK: begin
            if (w_accept) w_next = (w_lat == 1) ? ACK : WAIT;
            else          w_next = IDLE;
         end
         WAIT:    if (r_cnt == 3'd0) w_next = ACK;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      wr_ack = (r_state == ACK) &&  r_op_wr;
      rd_ack = (r_state == ACK) && !r_op_wr;
      err    = (r_state == ACK) &&  r_err;
      dout   = r_dout;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt   <= 3'd0;
         r_op_wr <= 1'b0;
         r_err   <= 1'b0;
         r_oob   <= 1'b0;
         r_addr  <= '0;
         r_di    <= '0;
         r_be    <= '0;
         r_dout  <= '0;
      end else begin
         if (w_accept) begin
            r_op_wr <= we;
            r_err   <= (we && rd) || w_in_oob;
            r_oob   <= w_in_oob;
            r_addr  <= addr;
            r_di    <= di;
            r_be    <= be;
            if (w_lat > 1) r_cnt <= 3'(w_lat - 2);
         end else if (r_state == WAIT && r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
         end
         if (w_complete && !w_c_wr)
            r_dout <= w_c_oob ? ERR_D : r_mem[w_idx];
      end
   end

   // Array is never cleared; reset only blocks an in-flight write.
   always_ff @(posedge clk) begin
      if (!reset && w_complete && w_c_wr && !w_c_oob) begin
         for (int i = 0; i < NB; i++)
            if (w_c_be[i]) r_mem[w_idx][8*i +: 8] <= w_c_di[8*i +: 8];
      end
   end

endmodule

// File: tb/tb_vproc_mem_model.sv
// Bench for vproc_mem_model: two instances (DEPTH=1000 lat 1/1, DEPTH=1024 rd 4 / wr 2)
// driven by a requester task; expectations queued at issue, compared at ack.
module tb_vproc_mem_model;

   localparam int RDLAT [2] = '{1, 4};
   localparam int WRLAT [2] = '{1, 2};
   localparam int DEP   [2] = '{1000, 1024};

   logic            clk = 1'b0;
   logic            reset;
   logic [1:0]      cs, we, rd;
   logic [1:0][3:0] be;
   logic [1:0][9:0] addr;
   logic [1:0][31:0] di, dout;
   logic [1:0]      wr_ack, rd_ack, err;

   always #5 clk = ~clk;

   vproc_mem_model #(.DEPTH(1000)) u_a (
      .clk(clk), .reset(reset), .cs(cs[0]), .we(we[0]), .rd(rd[0]), .be(be[0]),
      .addr(addr[0]), .di(di[0]), .dout(dout[0]), .wr_ack(wr_ack[0]),
      .rd_ack(rd_ack[0]), .err(err[0]));

   vproc_mem_model #(.RD_LATENCY(4), .WR_LATENCY(2)) u_b (
      .clk(clk), .reset(reset), .cs(cs[1]), .we(we[1]), .rd(rd[1]), .be(be[1]),
      .addr(addr[1]), .di(di[1]), .dout(dout[1]), .wr_ack(wr_ack[1]),
      .rd_ack(rd_ack[1]), .err(err[1]));

   typedef struct {
      bit          wr;
      int          lat;
      bit          e;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model [2][1024];
   logic [31:0] last_dout [2];
   int          n_cmp = 0;
   int          n_bad = 0;

   // Issue one access on instance d, hold it until ack, drop it in the ack cycle.
   task automatic access(input int d, input bit w, input bit r, input logic [3:0] b,
                         input logic [9:0] a, input logic [31:0] data, input string nm);
      exp_t e, g;
      int   n;
      bit   got;
      e.wr  = w;
      e.lat = w ? WRLAT[d] : RDLAT[d];
      e.e   = (w && r) || (int'(a) >= DEP[d]);
      if (w) begin
         if (int'(a) < DEP[d])
            for (int i = 0; i < 4; i++) if (b[i]) model[d][a][8*i +: 8] = data[8*i +: 8];
      end else begin
         last_dout[d] = (int'(a) >= DEP[d]) ? 32'hDEADC0DE : model[d][a];
      end
      e.data = last_dout[d];
      sb.push_back(e);
      cs[d] = 1'b1; we[d] = w; rd[d] = r; be[d] = b; addr[d] = a; di[d] = data;
      got = 1'b0;
      n   = 0;
      while (!got && n < 20) begin
         @(posedge clk); #1;
         n++;
         got = wr_ack[d] | rd_ack[d];
      end
      g = sb.pop_front();
      n_cmp++;
      if (!got) begin
         n_bad++;
         $display("FAIL %s timeout: no ack within %0d cycles (need ack at %0d)", nm, n, g.lat);
      end else begin
         if (n !== g.lat) begin
            n_bad++; $display("FAIL %s latency: got %0d need %0d", nm, n, g.lat);
         end
         n_cmp++;
         if (wr_ack[d] !== g.wr || rd_ack[d] !== !g.wr) begin
            n_bad++; $display("FAIL %s ack type: wr_ack=%b rd_ack=%b need wr=%b", nm, wr_ack[d], rd_ack[d], g.wr);
         end
         n_cmp++;
         if (err[d] !== g.e) begin
            n_bad++; $display("FAIL %s err: got %b need %b", nm, err[d], g.e);
         end
         n_cmp++;
         if (dout[d] !== g.data) begin
            n_bad++; $display("FAIL %s dout: got %h need %h", nm, dout[d], g.data);
         end
      end
      cs[d] = 1'b0; we[d] = 1'b0; rd[d] = 1'b0; be[d] = 4'h0; di[d] = 32'h5A5A5A5A;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cs = '0; we = '0; rd = '0; be = '0; addr = '0; di = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      last_dout[0] = '0; last_dout[1] = '0;
      for (int d = 0; d < 2; d++) begin
         n_cmp++;
         if (dout[d] !== 32'h0 || wr_ack[d] !== 1'b0 || rd_ack[d] !== 1'b0 || err[d] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset[%0d]: dout=%h wr=%b rd=%b err=%b need all 0", d, dout[d], wr_ack[d], rd_ack[d], err[d]);
         end
      end
   endtask

   task automatic test_write_read();
      access(0, 1, 0, 4'hF, 10'd5, 32'h12345678, "wr5");
      @(posedge clk); #1;
      n_cmp++;
      if (wr_ack[0] !== 1'b0 || rd_ack[0] !== 1'b0) begin
         n_bad++; $display("FAIL ack_one_cycle: wr=%b rd=%b need 0", wr_ack[0], rd_ack[0]);
      end
      access(0, 0, 1, 4'h0, 10'd5, 32'h0, "rd5");
   endtask

   task automatic test_byte_enable();
      access(0, 1, 0, 4'hF, 10'd7, 32'hFFFFFFFF, "wr7_full");
      access(0, 1, 0, 4'b0101, 10'd7, 32'hAABBCCDD, "wr7_be");
      access(0, 0, 1, 4'h0, 10'd7, 32'h0, "rd7");
      access(1, 1, 0, 4'hF, 10'd3, 32'h01020304, "b_wr3");
      access(1, 1, 0, 4'h0, 10'd3, 32'hFFFFFFFF, "b_wr3_be0");
      access(1, 0, 1, 4'h0, 10'd3, 32'h0, "b_rd3");
   endtask

   task automatic test_back_to_back();
      int   acks = 0;
      exp_t e;
      access(1, 1, 0, 4'hF, 10'd9, 32'h0BADF00D, "b_wr9");
      last_dout[1] = model[1][9];
      e.wr = 1'b0; e.e = 1'b0; e.data = model[1][9];
      e.lat = 4; sb.push_back(e);
      e.lat = 8; sb.push_back(e);
      cs[1] = 1'b1; rd[1] = 1'b1; addr[1] = 10'd9;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         if (wr_ack[1] | rd_ack[1]) begin
            acks++;
            n_cmp++;
            if (sb.size() == 0) begin
               n_bad++; $display("FAIL b2b extra ack at cycle %0d", c);
            end else begin
               e = sb.pop_front();
               if (c !== e.lat || rd_ack[1] !== 1'b1 || dout[1] !== e.data) begin
                  n_bad++;
                  $display("FAIL b2b ack: cycle %0d rd_ack=%b dout=%h need cycle %0d rd_ack=1 dout=%h", c, rd_ack[1], dout[1], e.lat, e.data);
               end
            end
         end
      end
      cs[1] = 1'b0; rd[1] = 1'b0;
      n_cmp++;
      if (acks !== 2) begin
         n_bad++; $display("FAIL b2b ack count: got %0d need 2", acks);
      end
      sb.delete();
   endtask

   task automatic test_out_of_range();
      access(0, 1, 0, 4'hF, 10'd999, 32'h99999999, "wr999");
      access(0, 1, 0, 4'hF, 10'd1000, 32'h11111111, "wr1000_oob");
      access(0, 0, 1, 4'h0, 10'd1000, 32'h0, "rd1000_oob");
      access(0, 0, 1, 4'h0, 10'd999, 32'h0, "rd999");
      access(0, 0, 1, 4'h0, 10'd1023, 32'h0, "rd1023_oob");
   endtask

   task automatic test_conflict_and_cs();
      int acks = 0;
      access(0, 1, 1, 4'hF, 10'd20, 32'hC0FFEE00, "we_rd_both");
      access(0, 0, 1, 4'h0, 10'd20, 32'h0, "rd20");
      cs[0] = 1'b0; we[0] = 1'b1; rd[0] = 1'b1; be[0] = 4'hF; addr[0] = 10'd20; di[0] = 32'h0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (wr_ack[0] | rd_ack[0] | err[0]) acks++;
      end
      we[0] = 1'b0; rd[0] = 1'b0;
      n_cmp++;
      if (acks !== 0) begin
         n_bad++; $display("FAIL cs0_no_ack: %0d ack cycles, need 0", acks);
      end
      access(0, 0, 1, 4'h0, 10'd20, 32'h0, "rd20_after_cs0");
   endtask

   task automatic test_reset_mid_read();
      int bad = 0;
      access(1, 1, 0, 4'hF, 10'd12, 32'hCAFEF00D, "b_wr12");
      access(1, 0, 1, 4'h0, 10'd12, 32'h0, "b_rd12");
      cs[1] = 1'b1; rd[1] = 1'b1; addr[1] = 10'd12;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1; cs[1] = 1'b0; rd[1] = 1'b0;
      for (int c = 3; c <= 8; c++) begin
         @(posedge clk); #1;
         reset = 1'b0;
         if (rd_ack[1] | wr_ack[1] | err[1] | (dout[1] !== 32'h0)) bad++;
      end
      last_dout[0] = '0; last_dout[1] = '0;
      n_cmp++;
      if (bad !== 0) begin
         n_bad++; $display("FAIL reset_mid_read: %0d cycles with nonzero outputs, need 0", bad);
      end
      n_cmp++;
      if (dout[0] !== 32'h0) begin
         n_bad++; $display("FAIL reset_a_dout: got %h need 0", dout[0]);
      end
      access(1, 0, 1, 4'h0, 10'd12, 32'h0, "b_rd12_after_reset");
      access(0, 0, 1, 4'h0, 10'd7, 32'h0, "rd7_after_reset");
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_enable();
      test_back_to_back();
      test_out_of_range();
      test_conflict_and_cs();
      test_reset_mid_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
